// File: rtl/intro_pkg.sv
// rtl/intro_pkg.sv - shared state encoding and default map geometry for the intro screen
package intro_pkg;

   localparam int TILE_SHIFT_DEF = 4;
   localparam int MAP_W_DEF      = 30;
   localparam int MAP_H_DEF      = 30;

   typedef enum logic [1:0] {
      ST_REVEAL = 2'd0,
      ST_HOLD   = 2'd1,
      ST_DONE   = 2'd2
   } intro_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/intro_rom.sv
// rtl/intro_rom.sv - combinational title map: tile index in, palette index out
module intro_rom
   import intro_pkg::*;
#(
   parameter int IDX_W      = 10,
   parameter int COLOR_BITS = 2
) (
   input  logic [IDX_W-1:0]      idx,
   output logic [COLOR_BITS-1:0] color
);

   // Map art is a bit-fold of the tile index: each index bit flips one palette bit.
   always_comb begin
      color = '0;
      for (int i = 0; i < IDX_W; i++) begin
         color[i % COLOR_BITS] = color[i % COLOR_BITS] ^ idx[i];
      end
   end

endmodule

// File: rtl/intro_animator.sv
// rtl/intro_animator.sv - column-reveal / blink title animation with start-key exit
module intro_animator
   import intro_pkg::*;
#(
   parameter int TILE_SHIFT    = TILE_SHIFT_DEF,
   parameter int MAP_W         = MAP_W_DEF,
   parameter int MAP_H         = MAP_H_DEF,
   parameter int COLOR_BITS    = 2,
   parameter int REVEAL_FRAMES = 4,
   parameter int BLINK_FRAMES  = 30,
   parameter int BLINK_ROW_LO  = 21,
   parameter int BLINK_ROW_HI  = 25
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_clk,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   input  logic                  start_key,
   output logic [COLOR_BITS-1:0] intro,
   output logic                  intro_active,
   output logic                  game_start
);

   localparam int IDX_W      = $clog2(MAP_W * MAP_H);
   localparam int MAX_FRAMES = max_int(REVEAL_FRAMES, BLINK_FRAMES);
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   localparam int COL_W      = (MAP_W > 1) ? $clog2(MAP_W) : 1;

   localparam logic [CNT_W-1:0] REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [COL_W-1:0] COL_LAST    = COL_W'(MAP_W - 1);
   localparam logic [9:0]       MAP_W_10    = 10'(MAP_W);
   localparam logic [9:0]       MAP_H_10    = 10'(MAP_H);
   localparam logic [9:0]       BAND_LO_10  = 10'(BLINK_ROW_LO);
   localparam logic [9:0]       BAND_HI_10  = 10'(BLINK_ROW_HI);

   intro_state_e          state_q, state_d;
   logic [COL_W-1:0]      reveal_col_q, reveal_col_d;
   logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic                  blink_q, blink_d;
   logic                  frame_clk_q, frame_clk_d;
   logic                  start_key_q, start_key_d;
   logic [COLOR_BITS-1:0] intro_q, intro_d;
   logic                  game_start_q, game_start_d;

   logic                  frame_tick;
   logic                  key_edge;
   logic [9:0]            col, row;
   logic [IDX_W-1:0]      tile_idx;
   logic [COLOR_BITS-1:0] rom_color;
   logic                  in_map, in_band, visible;

   assign col      = DrawX >> TILE_SHIFT;
   assign row      = DrawY >> TILE_SHIFT;
   // Out-of-map coordinates may alias here; they are masked by in_map below.
   assign tile_idx = IDX_W'(row) * IDX_W'(MAP_W) + IDX_W'(col);

   intro_rom #(
      .IDX_W      (IDX_W),
      .COLOR_BITS (COLOR_BITS)
   ) u_rom (
      .idx   (tile_idx),
      .color (rom_color)
   );

   always_comb begin
      frame_clk_d  = frame_clk;
      start_key_d  = start_key;
      frame_tick   = frame_clk & ~frame_clk_q;
      key_edge     = start_key & ~start_key_q;
      state_d      = state_q;
      reveal_col_d = reveal_col_q;
      frame_cnt_d  = frame_cnt_q;
      blink_d      = blink_q;
      game_start_d = 1'b0;

      case (state_q)
         ST_REVEAL: begin
            if (key_edge) begin
               state_d      = ST_HOLD;
               reveal_col_d = COL_LAST;
               frame_cnt_d  = '0;
               blink_d      = 1'b0;
            end else if (frame_tick) begin
               if (frame_cnt_q == REVEAL_LAST) begin
                  frame_cnt_d = '0;
                  if (reveal_col_q == COL_LAST) begin
                     state_d = ST_HOLD;
                     blink_d = 1'b0;
                  end else begin
                     reveal_col_d = reveal_col_q + COL_W'(1);
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (key_edge) begin
               state_d      = ST_DONE;
               game_start_d = 1'b1;
               frame_cnt_d  = '0;
            end else if (frame_tick) begin
               if (frame_cnt_q == BLINK_LAST) begin
                  frame_cnt_d = '0;
                  blink_d     = ~blink_q;
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
         end
         default: state_d = ST_REVEAL;
      endcase

      in_map  = (col < MAP_W_10) && (row < MAP_H_10);
      in_band = (row >= BAND_LO_10) && (row <= BAND_HI_10);
      case (state_q)
         ST_REVEAL: visible = (col <= 10'(reveal_col_q));
         ST_HOLD:   visible = !(blink_q && in_band);
         default:   visible = 1'b0;
      endcase
      intro_d = (in_map && visible) ? rom_color : '0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_REVEAL;
         reveal_col_q <= '0;
         frame_cnt_q  <= '0;
         blink_q      <= 1'b0;
         frame_clk_q  <= 1'b0;
         start_key_q  <= 1'b0;
         intro_q      <= '0;
         game_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         reveal_col_q <= reveal_col_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_q      <= blink_d;
         frame_clk_q  <= frame_clk_d;
         start_key_q  <= start_key_d;
         intro_q      <= intro_d;
         game_start_q <= game_start_d;
      end
   end

   assign intro        = intro_q;
   assign intro_active = (state_q != ST_DONE);
   assign game_start   = game_start_q;

endmodule
